// File: rtl/ntt_coeff_ram.sv
// 1R/1W coefficient RAM for the NTT datapath with a zero-fill engine after reset or clr.
// Read latency 1 cycle (2 when NTT_RAM_OUT_REG_EN is defined); write-first on same-address collision.
// No backpressure: rd/wr are ignored while ready=0, and rd_data must be taken on its rd_valid cycle.
module ntt_coeff_ram #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    output logic              ready,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [WORD_W-1:0] mem [DEPTH];

    logic              rd_in_range;
    logic              wr_in_range;
    logic              rd_acc;
    logic              wr_acc;
    logic              fwd_hit;
    logic [WORD_W-1:0] rd_next;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WORD_W-1:0] mem_wdata;

    logic              rd_valid_s1;
    logic [WORD_W-1:0] rd_data_s1;

    // A power-of-two array is covered by every address value, so no range compare is needed.
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_pow2
            assign rd_in_range = 1'b1;
            assign wr_in_range = 1'b1;
        end else begin : g_npow2
            assign rd_in_range = (rd_addr < ADDR_W'(DEPTH));
            assign wr_in_range = (wr_addr < ADDR_W'(DEPTH));
        end
    endgenerate

    // ready is high exactly while in ST_RUN, so it doubles as the port-accept qualifier.
    assign rd_acc  = ready & rd_en;
    assign wr_acc  = ready & wr_en & wr_in_range & ~clr;
    assign fwd_hit = wr_acc & (wr_addr == rd_addr);

    always_comb begin
        rd_next = '0;
        if (rd_in_range) begin
            rd_next = fwd_hit ? wr_data : mem[rd_addr];
        end
    end

    // The single physical write port is shared by the zero-fill engine and the user port.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt;
        mem_wdata = '0;
        if (state == ST_INIT) begin
            mem_we = ~clr;
        end else if (wr_acc) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (state == ST_INIT) begin
            if (clr) begin
                cnt <= '0;
            end else if (cnt == LAST_ADDR) begin
                state <= ST_RUN;
                ready <= 1'b1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            if (clr) begin
                state <= ST_INIT;
                ready <= 1'b0;
                cnt   <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_s1 <= 1'b0;
            rd_data_s1  <= '0;
        end else begin
            rd_valid_s1 <= rd_acc;
            if (rd_acc) begin
                rd_data_s1 <= rd_next;
            end
        end
    end

`ifdef NTT_RAM_OUT_REG_EN
    logic              rd_valid_s2;
    logic [WORD_W-1:0] rd_data_s2;

    // Independent of clr so a read already in flight always delivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_s2 <= 1'b0;
            rd_data_s2  <= '0;
        end else begin
            rd_valid_s2 <= rd_valid_s1;
            if (rd_valid_s1) begin
                rd_data_s2 <= rd_data_s1;
            end
        end
    end

    assign rd_valid = rd_valid_s2;
    assign rd_data  = rd_data_s2;
`else
    assign rd_valid = rd_valid_s1;
    assign rd_data  = rd_data_s1;
`endif

endmodule

// File: tb/tb_ntt_coeff_ram.sv
// Bench for ntt_coeff_ram: a 128-word and a 100-word instance run in lockstep against
// a per-word array model; directed scenarios followed by randomized read/write traffic.
`timescale 1ns/1ps
module tb_ntt_coeff_ram;

    localparam int W  = 16;
    localparam int AW = 7;
    localparam int D0 = 128;
    localparam int D1 = 100;
`ifdef NTT_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr      [2];
    logic          rd_en    [2];
    logic [AW-1:0] rd_addr  [2];
    logic          wr_en    [2];
    logic [AW-1:0] wr_addr  [2];
    logic [W-1:0]  wr_data  [2];
    logic          ready    [2];
    logic          rd_valid [2];
    logic [W-1:0]  rd_data  [2];

    // Reference model: word contents, cycles left until ready, output pipeline.
    logic [W-1:0]  mem_m    [2][128];
    int            init_left[2];
    logic          s1_v     [2];
    logic [W-1:0]  s1_d     [2];
    logic          o_v      [2];
    logic [W-1:0]  o_d      [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ntt_coeff_ram #(.WORD_W(W), .DEPTH(D0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr[0]),
        .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .ready(ready[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0])
    );

    ntt_coeff_ram #(.WORD_W(W), .DEPTH(D1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr[1]),
        .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .ready(ready[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1])
    );

    function automatic int dep(input int k);
        return (k == 0) ? D0 : D1;
    endfunction

    task automatic expect_bit(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic expect_word(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic expect_int(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            init_left[k] = dep(k);
            s1_v[k] = 1'b0; s1_d[k] = '0;
            o_v[k]  = 1'b0; o_d[k]  = '0;
            for (int i = 0; i < 128; i++) mem_m[k][i] = '0;
        end
    endtask

    // Applies the port rules for one clock edge using the inputs currently driven.
    task automatic model_edge(input int k);
        int           d;
        logic         acc;
        logic         wr_ok;
        logic [W-1:0] val;
        d     = dep(k);
        acc   = 1'b0;
        val   = '0;
        if (init_left[k] == 0) begin
            wr_ok = wr_en[k] && !clr[k] && (int'(wr_addr[k]) < d);
            if (rd_en[k]) begin
                acc = 1'b1;
                if (int'(rd_addr[k]) >= d)                     val = '0;
                else if (wr_ok && (wr_addr[k] == rd_addr[k]))  val = wr_data[k];
                else                                           val = mem_m[k][rd_addr[k]];
            end
            if (wr_ok) mem_m[k][wr_addr[k]] = wr_data[k];
            if (clr[k]) begin
                init_left[k] = d;
                for (int i = 0; i < 128; i++) mem_m[k][i] = '0;
            end
        end else begin
            init_left[k] = clr[k] ? d : init_left[k] - 1;
        end
        if (LAT == 2) begin
            o_v[k] = s1_v[k];
            if (s1_v[k]) o_d[k] = s1_d[k];
        end
        s1_v[k] = acc;
        if (acc) s1_d[k] = val;
        if (LAT == 1) begin
            o_v[k] = acc;
            if (acc) o_d[k] = val;
        end
    endtask

    task automatic check(input int k);
        expect_bit($sformatf("ready%0d", k), ready[k], (init_left[k] == 0));
        expect_bit($sformatf("rd_valid%0d", k), rd_valid[k], o_v[k]);
        expect_word($sformatf("rd_data%0d", k), rd_data[k], o_d[k]);
    endtask

    task automatic tick();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        check(0);
        check(1);
    endtask

    task automatic idle(input int k);
        clr[k] = 1'b0; rd_en[k] = 1'b0; wr_en[k] = 1'b0;
        rd_addr[k] = '0; wr_addr[k] = '0; wr_data[k] = '0;
    endtask

    task automatic idle_all();
        idle(0);
        idle(1);
    endtask

    task automatic rnd_inputs(input int k);
        clr[k]     = ($urandom_range(0, 199) == 0);
        rd_en[k]   = $urandom_range(0, 1) == 1;
        wr_en[k]   = $urandom_range(0, 1) == 1;
        wr_addr[k] = AW'($urandom_range(0, 127));
        rd_addr[k] = ($urandom_range(0, 3) == 0) ? wr_addr[k] : AW'($urandom_range(0, 127));
        wr_data[k] = W'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            expect_bit($sformatf("rst_ready%0d", k), ready[k], 1'b0);
            expect_bit($sformatf("rst_valid%0d", k), rd_valid[k], 1'b0);
            expect_word($sformatf("rst_data%0d", k), rd_data[k], '0);
        end
        rst_n = 1'b1;
    endtask

    // Counts cycles until instance k reports ready, optionally with junk traffic meant to be ignored.
    task automatic wait_ready(input int k, input bit junk, output int n);
        n = 0;
        while (ready[k] !== 1'b1 && n < 400) begin
            if (junk) begin
                rnd_inputs(0); rnd_inputs(1);
                clr[0] = 1'b0; clr[1] = 1'b0;
            end
            tick();
            n++;
        end
        idle_all();
    endtask

    // Issues one read on instance k and waits until its result is on the outputs.
    task automatic read_one(input int k, input int addr);
        idle_all();
        rd_en[k] = 1'b1; rd_addr[k] = AW'(addr);
        tick();
        idle_all();
        for (int i = 1; i < LAT; i++) tick();
    endtask

    task automatic write_one(input int k, input int addr, input logic [W-1:0] data);
        idle_all();
        wr_en[k] = 1'b1; wr_addr[k] = AW'(addr); wr_data[k] = data;
        tick();
        idle_all();
    endtask

    task automatic read_sweep(input int k, input int n);
        idle_all();
        for (int i = 0; i < n; i++) begin
            rd_en[k] = 1'b1; rd_addr[k] = AW'(i);
            tick();
        end
        idle_all();
        for (int i = 0; i < LAT; i++) tick();
    endtask

    initial begin
        int n;
        idle_all();

        // Reset, init duration, all words zero.
        do_reset();
        wait_ready(0, 1'b0, n);
        expect_int("init_cycles", n, D0);
        read_sweep(0, D0);
        read_sweep(1, D1);

        // Plain write then read.
        write_one(0, 5, 16'h1234);
        read_one(0, 5);
        expect_bit("wr_rd_valid", rd_valid[0], 1'b1);
        expect_word("wr_rd_data", rd_data[0], 16'h1234);

        // Same-address write/read collision returns the new data.
        write_one(0, 9, 16'h0001);
        wr_en[0] = 1'b1; wr_addr[0] = AW'(9); wr_data[0] = 16'hBEEF;
        rd_en[0] = 1'b1; rd_addr[0] = AW'(9);
        tick();
        idle_all();
        for (int i = 1; i < LAT; i++) tick();
        expect_word("fwd_data", rd_data[0], 16'hBEEF);
        read_one(0, 9);
        expect_word("fwd_later", rd_data[0], 16'hBEEF);

        // Randomized traffic, including out-of-range addresses on the 100-word instance.
        for (int c = 0; c < 600; c++) begin
            rnd_inputs(0);
            rnd_inputs(1);
            tick();
        end
        idle_all();
        wait_ready(0, 1'b0, n);
        wait_ready(1, 1'b0, n);

        // Clear with a colliding write and a read in the same cycle.
        for (int i = 0; i < D0; i++) begin
            wr_en[0] = 1'b1; wr_addr[0] = AW'(i); wr_data[0] = W'(i + 1);
            tick();
        end
        clr[0] = 1'b1;
        wr_en[0] = 1'b1; wr_addr[0] = AW'(3); wr_data[0] = 16'h7777;
        rd_en[0] = 1'b1; rd_addr[0] = AW'(3);
        tick();
        idle_all();
        for (int i = 1; i < LAT; i++) tick();
        expect_word("clr_rd_old", rd_data[0], 16'h0004);
        wait_ready(0, 1'b1, n);
        expect_int("clr_cycles", n, D0 - (LAT - 1));
        read_one(0, 3);
        expect_word("clr_word3", rd_data[0], 16'h0000);
        read_sweep(0, D0);

        // Async reset in the middle of a fill.
        write_one(0, 17, 16'hC0DE);
        read_one(0, 17);
        expect_word("pre_rst_data", rd_data[0], 16'hC0DE);
        clr[0] = 1'b1;
        tick();
        idle_all();
        for (int i = 0; i < 40; i++) tick();
        do_reset();
        wait_ready(0, 1'b0, n);
        expect_int("rst_mid_init_cycles", n, D0);

        // Non-power-of-two depth: out-of-range access.
        for (int i = 0; i < D1; i++) begin
            wr_en[1] = 1'b1; wr_addr[1] = AW'(i); wr_data[1] = W'(16'h5000 + i);
            tick();
        end
        write_one(1, 120, 16'hAAAA);
        read_one(1, 120);
        expect_bit("oor_valid", rd_valid[1], 1'b1);
        expect_word("oor_data", rd_data[1], 16'h0000);
        read_one(1, 99);
        expect_word("d100_last", rd_data[1], 16'h5063);
        read_sweep(1, D1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
